// File: rtl/prescaler_pkg.sv
// Shared constants and types for the prescaler tick scheduler.
package prescaler_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CW_DEF  = 16;
  localparam int unsigned PW_DEF  = 8;

  localparam logic [2:0] ADDR_PSC     = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_RELOAD0 = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } chan_state_e;

endpackage

// File: rtl/prescaler_ctrl_if.sv
// Valid/ready configuration write port of the prescaler tick scheduler.
interface prescaler_ctrl_if
  import prescaler_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_ready
  );
endinterface

// File: rtl/prescaler_chan.sv
// One scheduler channel: IDLE/RUN/DONE FSM, down-counter, shadow reload and registered tick.
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          base_tick_i,
  input  logic          en_set_i,
  input  logic          en_clr_i,
  input  logic          os_i,
  input  logic          reload_we_i,
  input  logic [CW-1:0] reload_i,
  output logic          tick_o,
  output logic          busy_o,
  output logic          os_clr_o
);

  chan_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] shadow_q;
  logic          tick_q;
  logic          expire;

  assign expire   = (state_q == StRun) && base_tick_i && (cnt_q == '0);
  // A disable on the expiry edge wins, so no EN hardware clear is requested then.
  assign os_clr_o = expire && os_i && !en_clr_i;
  assign busy_o   = (state_q == StRun);
  assign tick_o   = tick_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (reload_we_i) begin
        shadow_q <= reload_i;
      end
      if (en_clr_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (en_set_i) begin
              state_q <= StRun;
              cnt_q   <= shadow_q;
            end
          end
          StRun: begin
            if (base_tick_i) begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
              end else begin
                tick_q <= 1'b1;
                if (os_i) begin
                  state_q <= StDone;
                end else begin
                  cnt_q <= shadow_q;
                end
              end
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/prescaler_ctrl.sv
// Tick scheduler top: config port, PSC/CTRL registers, shared base divider and NCH channels.
module prescaler_ctrl
  import prescaler_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned PW  = PW_DEF
) (
  input  logic               PCLK,
  input  logic               PRESET,
  prescaler_ctrl_if.slave    cfg,
  output logic               base_tick,
  output logic [NCH-1:0]     tick,
  output logic [NCH-1:0]     busy
);

  logic           cfg_ready_q;
  logic           wr;
  logic           wr_psc;
  logic           wr_ctrl;
  logic [NCH-1:0] wr_reload;

  logic [PW-1:0]  psc_q;
  logic [PW-1:0]  base_cnt_q, base_cnt_d;
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] os_q, os_d;
  logic [NCH-1:0] en_set, en_clr, os_clr;

  assign cfg.cfg_ready = cfg_ready_q;
  assign wr            = cfg.cfg_valid && cfg_ready_q;
  assign wr_psc        = wr && (cfg.cfg_addr == ADDR_PSC);
  assign wr_ctrl       = wr && (cfg.cfg_addr == ADDR_CTRL);

  assign en_set    = {NCH{wr_ctrl}} & cfg.cfg_wdata[NCH-1:0] & ~en_q;
  assign en_clr    = {NCH{wr_ctrl}} & ~cfg.cfg_wdata[NCH-1:0];
  assign base_tick = (base_cnt_q == psc_q);

  always_comb begin
    en_d = en_q;
    os_d = os_q;
    if (wr_ctrl) begin
      en_d = cfg.cfg_wdata[NCH-1:0];
      os_d = cfg.cfg_wdata[4 +: NCH];
    end
    en_d = en_d & ~os_clr;
  end

  // Divider only runs while some channel is counting, so idle channels start phase-aligned.
  always_comb begin
    base_cnt_d = base_cnt_q + PW'(1);
    if (wr_psc || (busy == '0) || base_tick) begin
      base_cnt_d = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cfg_ready_q <= 1'b0;
      psc_q       <= '0;
      base_cnt_q  <= '0;
      en_q        <= '0;
      os_q        <= '0;
    end else begin
      cfg_ready_q <= !wr;
      base_cnt_q  <= base_cnt_d;
      en_q        <= en_d;
      os_q        <= os_d;
      if (wr_psc) begin
        psc_q <= cfg.cfg_wdata[PW-1:0];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr_reload[i] = wr && (cfg.cfg_addr == ADDR_RELOAD0 + 3'(i));

    prescaler_chan #(
      .CW (CW)
    ) u_chan (
      .clk_i       (PCLK),
      .rst_i       (PRESET),
      .base_tick_i (base_tick),
      .en_set_i    (en_set[i]),
      .en_clr_i    (en_clr[i]),
      .os_i        (os_q[i]),
      .reload_we_i (wr_reload[i]),
      .reload_i    (cfg.cfg_wdata),
      .tick_o      (tick[i]),
      .busy_o      (busy[i]),
      .os_clr_o    (os_clr[i])
    );
  end

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Directed self-checking bench for prescaler_ctrl.
module tb_prescaler_ctrl;
  import prescaler_pkg::*;

  logic       PCLK   = 1'b0;
  logic       PRESET = 1'b1;
  logic       base_tick;
  logic [3:0] tick;
  logic [3:0] busy;

  int cyc   = 0;
  int nchk  = 0;
  int nfail = 0;

  prescaler_ctrl_if #(.CW(16)) cfg_if ();

  prescaler_ctrl #(
    .NCH (4),
    .CW  (16),
    .PW  (8)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cfg       (cfg_if),
    .base_tick (base_tick),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the cycle number of the accepting edge in e0.
  task automatic wr(input logic [2:0] a, input logic [15:0] d, output int e0);
    int n = 0;
    @(negedge PCLK);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_wdata = d;
    while (cfg_if.cfg_ready !== 1'b1 && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    chk("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(posedge PCLK);
    #1;
    e0 = cyc;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge PCLK);
      if (tick[ch] === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int e0, e, at, prev, bad;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_wdata = '0;

    // Reset values
    #2;
    chk("rst_ready", 32'(cfg_if.cfg_ready), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_base_tick", 32'(base_tick), 1);
    @(negedge PCLK);
    chk("rst_ready_held", 32'(cfg_if.cfg_ready), 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("ready_after_release", 32'(cfg_if.cfg_ready), 1);

    // Idle: PSC=0 keeps base_tick high, PSC=3 with nothing running keeps it low
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (base_tick !== 1'b1 || tick !== 4'h0 || busy !== 4'h0) bad++;
    end
    chk("idle_psc0", bad, 0);
    wr(3'd0, 16'd3, e);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (base_tick !== 1'b0 || tick !== 4'h0 || busy !== 4'h0) bad++;
    end
    chk("idle_base_held", bad, 0);

    // ch0 periodic, PSC=3 RELOAD=2 -> period 12
    wr(3'd4, 16'd2, e);
    wr(3'd1, 16'h0001, e0);
    chk("ch0_busy", 32'(busy), 32'h1);
    wait_tick(0, 40, at);
    chk("ch0_first", at - e0, 12);
    @(negedge PCLK);
    chk("ch0_width", 32'(tick), 0);
    prev = at;
    wait_tick(0, 40, at);
    chk("ch0_period1", at - prev, 12);
    prev = at;
    wait_tick(0, 40, at);
    chk("ch0_period2", at - prev, 12);
    wr(3'd1, 16'h0000, e);
    chk("ch0_disabled", 32'(busy), 0);

    // ch1 one-shot, PSC=0 RELOAD=4
    wr(3'd0, 16'd0, e);
    wr(3'd5, 16'd4, e);
    wr(3'd1, 16'h0022, e0);
    wait_tick(1, 20, at);
    chk("ch1_oneshot", at - e0, 5);
    @(negedge PCLK);
    chk("ch1_busy_after", 32'(busy), 0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (tick !== 4'h0) bad++;
    end
    chk("ch1_no_more_ticks", bad, 0);
    // EN[1] was cleared by hardware, so writing it again is a fresh 0->1
    wr(3'd1, 16'h0022, e0);
    chk("ch1_rearm_busy", 32'(busy), 32'h2);
    wait_tick(1, 20, at);
    chk("ch1_rearm_tick", at - e0, 5);

    // Mid-period RELOAD change: PSC=1 RELOAD 3 -> 7
    wr(3'd0, 16'd1, e);
    wr(3'd4, 16'd3, e);
    wr(3'd1, 16'h0001, e0);
    wait_tick(0, 40, at);
    chk("ch0_psc1_first", at - e0, 8);
    prev = at;
    repeat (3) @(negedge PCLK);
    wr(3'd4, 16'd7, e);
    wait_tick(0, 40, at);
    chk("ch0_cur_period", at - prev, 8);
    prev = at;
    wait_tick(0, 40, at);
    chk("ch0_new_period1", at - prev, 16);
    prev = at;
    wait_tick(0, 40, at);
    chk("ch0_new_period2", at - prev, 16);
    wr(3'd1, 16'h0000, e);

    // Back-to-back writes with valid held
    repeat (2) @(negedge PCLK);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 3'd6;
    cfg_if.cfg_wdata = 16'd5;
    chk("b2b_0", 32'(cfg_if.cfg_ready), 1);
    @(negedge PCLK);
    chk("b2b_1", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_addr  = 3'd2;
    cfg_if.cfg_wdata = 16'h0055;
    @(negedge PCLK);
    chk("b2b_2", 32'(cfg_if.cfg_ready), 1);
    @(negedge PCLK);
    chk("b2b_3", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_addr  = 3'd7;
    cfg_if.cfg_wdata = 16'd9;
    @(negedge PCLK);
    chk("b2b_4", 32'(cfg_if.cfg_ready), 1);
    @(negedge PCLK);
    chk("b2b_5", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_addr  = 3'd3;
    cfg_if.cfg_wdata = 16'h00aa;
    @(negedge PCLK);
    chk("b2b_6", 32'(cfg_if.cfg_ready), 1);
    @(negedge PCLK);
    chk("b2b_7", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;

    // ch2 (RELOAD 5, PSC 0) disabled on its expiry edge e0+6
    wr(3'd0, 16'd0, e);
    wr(3'd1, 16'h0004, e0);
    do @(negedge PCLK); while (cyc < e0 + 5);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 3'd1;
    cfg_if.cfg_wdata = 16'h0000;
    chk("ch2_disable_ready", 32'(cfg_if.cfg_ready), 1);
    chk("ch2_still_running", 32'(busy), 32'h4);
    @(posedge PCLK);
    #1;
    cfg_if.cfg_valid = 1'b0;
    chk("ch2_disable_busy", 32'(busy), 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (tick !== 4'h0) bad++;
    end
    chk("ch2_no_tick", bad, 0);

    // ch3 (RELOAD 9) reset mid-count
    wr(3'd1, 16'h0008, e0);
    repeat (4) @(negedge PCLK);
    chk("ch3_running", 32'(busy), 32'h8);
    PRESET = 1'b1;
    #1;
    chk("midrst_tick", 32'(tick), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(cfg_if.cfg_ready), 0);
    chk("midrst_base_tick", 32'(base_tick), 1);
    @(negedge PCLK);
    PRESET = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK);
      if (tick !== 4'h0 || busy !== 4'h0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_ready", 32'(cfg_if.cfg_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
